exec_sched: RTL
===============

Name: exec_sched

Overview:
Run-level scheduler for the CGRA configuration/execution path. On start it pulses the configuration loader, waits for the loaded indication, then gates the PC enable for a programmed number of loop iterations. PC advances stall on operand/result backpressure. After the last iteration it drains the PE pipeline and reports done with cycle and iteration counters.

Parameters:
CNT_WIDTH, 32, width of iteration and cycle counters and of the programmed lengths
PIPE_DEPTH, 8, drain cycles after the last PC advance before done (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset (0 = reset)
start  in  1  single-cycle run request; sampled only in IDLE
num_conf  in  CNT_WIDTH  configurations in the program; latched on accepted start
start_loop  in  CNT_WIDTH  first configuration of the loop body; latched on accepted start
num_iter  in  CNT_WIDTH  loop iterations to execute; latched on accepted start
conf_loaded  in  1  loader finished writing configuration memory (level or pulse)
in_valid  in  1  operand streams can supply data this cycle
out_ready  in  1  result sink can accept data this cycle
load_start  out  1  one-cycle pulse to the configuration loader
en_pc  out  1  PC advance enable
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
iter_cnt  out  CNT_WIDTH  completed iterations of the current/last run
cycle_cnt  out  CNT_WIDTH  cycles in RUN/STALL of the current/last run

Behaviour:
- Reset (rst=0 at posedge): state IDLE. All outputs 0. Counters 0. Latched lengths 0. A reset mid-run aborts immediately with no done pulse.
- States: IDLE, LOAD, RUN, DRAIN, FIN.
- IDLE: start=1 latches num_conf, start_loop, num_iter, clears iter_cnt/cycle_cnt, asserts load_start for exactly the next cycle, and moves to LOAD. busy goes 1 in the same next cycle.
- LOAD: wait for conf_loaded=1.
  - num_conf==0 or num_iter==0: go to FIN (no en_pc ever).
  - Otherwise: go to RUN with step counter 0, body end = num_conf-1.
- Effective loop start: ls = start_loop if start_loop < num_conf, else num_conf-1 (clamp).
- RUN: en_pc = in_valid & out_ready (combinational from state and inputs). cycle_cnt increments every RUN cycle, stalled or not.
  - The step index advances only when en_pc=1.
  - First pass covers indices 0..num_conf-1. Later passes cover ls..num_conf-1.
  - en_pc=1 at index num_conf-1: iter_cnt++ and the index reloads to ls.
  - If that increment makes iter_cnt==num_iter, the next state is DRAIN.
- DRAIN: en_pc=0. Count PIPE_DEPTH cycles, then go to FIN. in_valid/out_ready are ignored.
- FIN: done=1 for one cycle, busy=0 from the next cycle, return to IDLE. Counters hold until the next accepted start.
- start while busy is ignored. start in the same cycle FIN returns to IDLE is ignored (only sampled while in IDLE).
- Total en_pc pulses per run = num_conf + (num_iter-1)*(num_conf-ls).
- All arithmetic is unsigned CNT_WIDTH. cycle_cnt saturates at all-ones. iter_cnt cannot exceed num_iter.
- Latency:
  - start to load_start: 1 cycle.
  - conf_loaded to first possible en_pc: 1 cycle.
  - Last en_pc to done: PIPE_DEPTH+1 cycles.

Test Plan:
- Basic run: num_conf=4, start_loop=1, num_iter=3, in_valid=out_ready=1, conf_loaded 5 cycles after load_start -> exactly 10 en_pc pulses (4+3+3) in consecutive cycles. iter_cnt 1,2,3 after pulses 4,7,10. done pulse 9 cycles after the last en_pc (PIPE_DEPTH=8). cycle_cnt=10.
- Backpressure: same program, out_ready low on alternate RUN cycles and in_valid low for 3 cycles -> still 10 en_pc pulses, never while either input is low. cycle_cnt = 10 + stall cycles.
- Degenerate lengths:
  - num_iter=0 -> no en_pc; done 1 cycle after conf_loaded; iter_cnt=0.
  - num_conf=0 -> same response.
  - start_loop=9 with num_conf=4, num_iter=3 -> clamp ls=3; 6 en_pc pulses total.
- Start handling: start held high throughout a run -> exactly one load_start per run. Re-accept occurs only after done. Counters clear on the new accept, not at done.
- Reset mid-run: rst=0 during RUN after 5 en_pc -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent start runs a full program correctly.
- Single-config loop: num_conf=1, start_loop=0, num_iter=5 -> 5 consecutive en_pc pulses; iter_cnt increments on each one; done after drain.

Source files
------------

// File: rtl/exec_sched.sv
// Run-level scheduler for the CGRA configuration/execution path.
// Pulses the loader, gates PC advances over the loop body, drains, reports.
module exec_sched #(
    parameter int CNT_WIDTH  = 32,
    parameter int PIPE_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_conf,
    input  logic [CNT_WIDTH-1:0] start_loop,
    input  logic [CNT_WIDTH-1:0] num_iter,
    input  logic                 conf_loaded,
    input  logic                 in_valid,
    input  logic                 out_ready,
    output logic                 load_start,
    output logic                 en_pc,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] iter_cnt,
    output logic [CNT_WIDTH-1:0] cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    localparam int DW = $clog2(PIPE_DEPTH + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] num_conf_q, num_conf_d;
    logic [CNT_WIDTH-1:0] start_loop_q, start_loop_d;
    logic [CNT_WIDTH-1:0] num_iter_q, num_iter_d;
    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0] iter_q, iter_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic                 load_start_q, load_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [CNT_WIDTH-1:0] loop_start;
    logic [CNT_WIDTH-1:0] body_end;
    logic [CNT_WIDTH-1:0] iter_inc;
    logic                 adv;

    // Loop re-entry point is clamped into the program; PC gating.
    always_comb begin
        body_end   = num_conf_q - ONE;
        loop_start = (start_loop_q < num_conf_q) ? start_loop_q : body_end;
        iter_inc   = iter_q + ONE;
        adv        = (state_q == S_RUN) && in_valid && out_ready;
    end

    // Next-state and next-value logic for the whole scheduler.
    always_comb begin
        state_d      = state_q;
        num_conf_d   = num_conf_q;
        start_loop_d = start_loop_q;
        num_iter_d   = num_iter_q;
        idx_d        = idx_q;
        iter_d       = iter_q;
        cyc_d        = cyc_q;
        drain_d      = drain_q;
        busy_d       = busy_q;
        load_start_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_conf_d   = num_conf;
                    start_loop_d = start_loop;
                    num_iter_d   = num_iter;
                    iter_d       = '0;
                    cyc_d        = '0;
                    load_start_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = S_LOAD;
                end
            end
            S_LOAD: begin
                if (conf_loaded) begin
                    if (num_conf_q == '0 || num_iter_q == '0) begin
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        idx_d   = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cyc_q != CNT_MAX) begin
                    cyc_d = cyc_q + ONE;
                end
                if (adv) begin
                    if (idx_q == body_end) begin
                        iter_d = iter_inc;
                        idx_d  = loop_start;
                        if (iter_inc == num_iter_q) begin
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_FIN: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any run silently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            num_conf_q   <= '0;
            start_loop_q <= '0;
            num_iter_q   <= '0;
            idx_q        <= '0;
            iter_q       <= '0;
            cyc_q        <= '0;
            drain_q      <= '0;
            load_start_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_conf_q   <= num_conf_d;
            start_loop_q <= start_loop_d;
            num_iter_q   <= num_iter_d;
            idx_q        <= idx_d;
            iter_q       <= iter_d;
            cyc_q        <= cyc_d;
            drain_q      <= drain_d;
            load_start_q <= load_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign en_pc      = adv;
    assign load_start = load_start_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign iter_cnt   = iter_q;
    assign cycle_cnt  = cyc_q;

endmodule
